// File: rtl/rram_seq_pkg.sv
// Shared types and helpers for the RRAM crossbar cell sequencer.
// Holds the FSM state encoding, scan modes and the pulse-length clamp.
package rram_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    PULSE,
    GAP,
    DONE
  } state_t;

  localparam logic [1:0] MODE_SINGLE = 2'd0;
  localparam logic [1:0] MODE_ROW    = 2'd1;
  localparam logic [1:0] MODE_FULL   = 2'd2;

  function automatic logic [31:0] clamp_pulse(
    input logic [31:0] len
  );
    return (len == '0) ? 32'd1 : len;
  endfunction

endpackage

// File: rtl/rram_range_iter.sv
// Modulo-2^W range iterator: walks base..last, wrapping back to base.
// Value and its complement are both registered from one next value.
module rram_range_iter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] base,
  input  logic [W-1:0] last,
  input  logic         step,
  output logic [W-1:0] value,
  output logic [W-1:0] value_b,
  output logic         at_last
);

  logic [W-1:0] base_q;
  logic [W-1:0] last_q;
  logic [W-1:0] nxt;

  assign at_last = (value == last_q);

  always_comb begin
    nxt = value;
    if (load)
      nxt = base;
    else if (step)
      nxt = at_last ? base_q : value + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value   <= '0;
      value_b <= '1;
      base_q  <= '0;
      last_q  <= '0;
    end else begin
      value   <= nxt;
      value_b <= ~nxt;
      if (load) begin
        base_q <= base;
        last_q <= last;
      end
    end
  end

endmodule

// File: rtl/rram_cell_sequencer.sv
// Clocked RL/CL addressing sequencer for the RRAM crossbar macro.
// Single, row and full scans with break-before-make select pulses.
module rram_cell_sequencer
  import rram_seq_pkg::*;
#(
  parameter int ROW_W   = 11,
  parameter int COL_W   = 9,
  parameter int PULSE_W = 16,
  parameter int SETTLE  = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic [1:0]         mode_i,
  input  logic [ROW_W-1:0]   row_base_i,
  input  logic [ROW_W-1:0]   row_last_i,
  input  logic [COL_W-1:0]   col_base_i,
  input  logic [COL_W-1:0]   col_last_i,
  input  logic [PULSE_W-1:0] pulse_len_i,
  output logic [ROW_W-1:0]   rl_addr_o,
  output logic [ROW_W-1:0]   rl_addrb_o,
  output logic [COL_W-1:0]   cl_addr_o,
  output logic [COL_W-1:0]   cl_addrb_o,
  output logic               rl_sel_o,
  output logic               cl_sel_o,
  output logic               busy_o,
  output logic               cell_done_o,
  output logic               done_o
);

  localparam int SW    = $clog2(SETTLE + 1);
  localparam int CNT_W = (PULSE_W > SW) ? PULSE_W : SW;
  localparam logic [CNT_W-1:0] SET_M1 = CNT_W'(SETTLE - 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         mode_q;
  logic [PULSE_W-1:0] plen_q;
  logic               kill_q;
  logic               stop_q;
  logic               go;
  logic               more;
  logic               adv;
  logic               row_last;
  logic               col_last;
  logic               row_step;
  logic               col_step;

  assign go = (state == IDLE) && start_i && !abort_i;

  always_comb begin
    more = 1'b0;
    unique case (1'b1)
      (mode_q == MODE_ROW):  more = !row_last;
      (mode_q == MODE_FULL): more = !(row_last && col_last);
      default:               more = 1'b0;
    endcase
  end

  assign adv = (state == GAP) && (cnt == '0) && more
             && !(stop_q || abort_i);

  assign row_step = adv;
  assign col_step = adv && (mode_q == MODE_FULL) && row_last;

  rram_range_iter #(.W(ROW_W)) u_row (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (go),
    .base    (row_base_i),
    .last    (row_last_i),
    .step    (row_step),
    .value   (rl_addr_o),
    .value_b (rl_addrb_o),
    .at_last (row_last)
  );

  rram_range_iter #(.W(COL_W)) u_col (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .load    (go),
    .base    (col_base_i),
    .last    (col_last_i),
    .step    (col_step),
    .value   (cl_addr_o),
    .value_b (cl_addrb_o),
    .at_last (col_last)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= MODE_SINGLE;
      plen_q      <= '0;
      kill_q      <= 1'b0;
      stop_q      <= 1'b0;
      rl_sel_o    <= 1'b0;
      cl_sel_o    <= 1'b0;
      busy_o      <= 1'b0;
      cell_done_o <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      cell_done_o <= 1'b0;
      done_o      <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state  <= SETUP;
            cnt    <= SET_M1;
            mode_q <= mode_i;
            plen_q <= PULSE_W'(clamp_pulse(32'(pulse_len_i)));
            kill_q <= 1'b0;
            stop_q <= 1'b0;
            busy_o <= 1'b1;
          end
        end
        SETUP, PULSE: begin
          if (abort_i) begin
            state    <= GAP;
            cnt      <= SET_M1;
            kill_q   <= 1'b1;
            stop_q   <= 1'b1;
            rl_sel_o <= 1'b0;
            cl_sel_o <= 1'b0;
          end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (state == SETUP) begin
            state    <= PULSE;
            cnt      <= CNT_W'(plen_q - 1'b1);
            rl_sel_o <= 1'b1;
            cl_sel_o <= 1'b1;
          end else begin
            state       <= GAP;
            cnt         <= SET_M1;
            rl_sel_o    <= 1'b0;
            cl_sel_o    <= 1'b0;
            cell_done_o <= (SET_M1 == '0);
          end
        end
        GAP: begin
          stop_q <= stop_q | abort_i;
          if (cnt != '0) begin
            cnt         <= cnt - 1'b1;
            cell_done_o <= (cnt == CNT_W'(1)) && !kill_q;
          end else if (adv) begin
            state <= SETUP;
            cnt   <= SET_M1;
          end else begin
            state  <= DONE;
            done_o <= 1'b1;
          end
        end
        DONE: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rram_cell_sequencer.md
Name: rram_cell_sequencer

Overview:
- Parametrised successor to the fixed GPIO-driven RRAM crossbar addressing. Replaces static row/column decoding (address plus combinational complement) with a clocked sequencer.
- Drives RL/CL address buses, their complements and the RL/CL select strobes to the crossbar macro.
- Supports single-cell, row-scan and full-array scan with programmable pulse width and break-before-make dead time.
- Sits in the user analog wrapper between the (synchronised) control inputs and the TOP crossbar instance.

Parameters:
ROW_W, 11, row-line address width
COL_W, 9, column-line address width
PULSE_W, 16, pulse-length counter width
SETTLE, 4, dead cycles before and after every select pulse (≥1)

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous reset, active-high
start_i  in  1  begin operation (sampled in IDLE only)
abort_i  in  1  terminate current operation
mode_i  in  2  0=single cell, 1=row scan, 2=full scan, 3=single cell
row_base_i  in  ROW_W  first row
row_last_i  in  ROW_W  last row
col_base_i  in  COL_W  first column
col_last_i  in  COL_W  last column
pulse_len_i  in  PULSE_W  select-high cycles per cell
rl_addr_o  out  ROW_W  row address
rl_addrb_o  out  ROW_W  bitwise complement of rl_addr_o
cl_addr_o  out  COL_W  column address
cl_addrb_o  out  COL_W  bitwise complement of cl_addr_o
rl_sel_o  out  1  row select strobe
cl_sel_o  out  1  column select strobe
busy_o  out  1  high from the cycle after an accepted start until return to IDLE
cell_done_o  out  1  one-cycle pulse at the end of each cell's trailing GAP
done_o  out  1  one-cycle pulse on return to IDLE

Behaviour:
- Reset values (including reset mid-operation, applied on the next edge):
  - rl_addr_o=0, cl_addr_o=0, rl_addrb_o=all ones, cl_addrb_o=all ones.
  - sel outputs 0, busy_o/cell_done_o/done_o 0, state IDLE.
- All outputs are registered.
  - addrb is registered from the same next-state value as addr, so addrb == ~addr on every cycle.
  - rl_sel_o and cl_sel_o are always equal.
- Accepted start (IDLE, start_i=1, abort_i=0):
  - Latch mode, bases, lasts and pulse_len.
  - A latched pulse_len of 0 is treated as 1.
- FSM states and transitions:
  - IDLE: on accepted start -> SETUP.
  - SETUP: addresses already updated; sel=0 for SETTLE cycles -> PULSE.
  - PULSE: sel=1 for pulse_len cycles -> GAP.
  - GAP: sel=0 for SETTLE cycles.
    - If more cells remain: cell_done_o, advance the address, -> SETUP.
    - Otherwise: cell_done_o, -> DONE.
  - DONE: done_o=1 for one cycle; addresses hold last value -> IDLE.
- Timing:
  - Start accepted at edge 0: addresses valid and busy_o=1 from cycle 1.
  - sel rises at cycle 1+SETTLE.
  - Per-cell period = 2*SETTLE + pulse_len.
  - done_o follows the final cell_done_o by one cycle.
- Address changes happen only while sel=0 (break-before-make). The sequencer never changes an address with sel high.
- Iteration:
  - Mode 0/3: single cell (row_base, col_base).
  - Mode 1: col fixed at col_base; row runs base..last.
  - Mode 2: row is the inner loop and column the outer loop. At row wrap to row_base, column increments.
  - Increment is modulo 2^W. If last < base, the iterator wraps through all-ones to 0 and continues to last.
  - base == last gives one step.
- abort_i:
  - In SETUP or PULSE: sel drops next cycle, then a full GAP (SETTLE cycles), then DONE. No cell_done_o.
  - In GAP: finish GAP, then DONE.
  - In DONE: no effect.
  - In IDLE: suppresses a simultaneous start (abort wins).
- start_i while busy: ignored. Inputs changing while busy: ignored (latched copy used).

Decomposition:
- Package rram_seq_pkg:
  - state enum (IDLE, SETUP, PULSE, GAP, DONE);
  - mode constants MODE_SINGLE / MODE_ROW / MODE_FULL;
  - helper for the zero-pulse clamp.
- Sub-module rram_range_iter: parametrised width W; modulo-wrap counter.
  - Inputs: load, base, last, step.
  - Outputs: value, at_last.
  - Instantiated once for rows and once for columns.

Test Plan:
- Reset with outputs forced -> rl_addr_o=0, rl_addrb_o=11'h7FF, cl_addrb_o=9'h1FF, sel=0, busy_o=0 on the cycle after reset.
- SETTLE=4, mode 0, row_base=5, col_base=3, pulse_len=10 -> addr 5/3 at cycle 1, sel high cycles 5–14, cell_done_o at cycle 18, done_o at cycle 19, busy_o low at cycle 20.
- Mode 2, rows 2..3, cols 7..8, pulse_len=2 -> cells (2,7), (3,7), (2,8), (3,8) in that order; 4 cell_done_o pulses, each 10 cycles apart; addr never changes while sel=1.
- Mode 1, row_base=11'h7FE, row_last=1 -> rows 7FE, 7FF, 0, 1 (4 cells); addrb == ~addr checked every cycle.
- pulse_len=0 -> sel high exactly 1 cycle.
- Abort at PULSE cycle 3 -> sel low next cycle, 4 GAP cycles, done_o, no cell_done_o.
- start_i and abort_i asserted together in IDLE -> stays IDLE, busy_o=0.
- Reset asserted mid-PULSE -> sel=0 and all outputs at reset values next cycle.
